// File: rtl/lfsr_byte_fifo.sv
// -----------------------------------------------------------------------------
// lfsr_byte_fifo
//
// Takes the serial random bit stream from the LFSR peripheral, packs it
// MSB-first into bytes and queues the bytes in a small circular FIFO. A host
// on the 8-bit Wishbone bus pops bytes from DATA and reads status and control.
//
// Register map (i_wb_addr):
//   0 DATA   R : FIFO head. A read of a non-empty FIFO pops one byte.
//                An empty FIFO reads 0x00 and nothing is popped.
//   1 STATUS R : [3:0] count, [4] empty, [5] full, [6] overflow (sticky),
//                [7] enable
//   2 CTRL  RW : write bit0 = enable capture, bit1 = clear (self-clearing);
//                read returns {7'b0, enable}
//   3        R : 0x00
//
// Parameters:
//   FIFO_AW   : FIFO address width, depth = 2**FIFO_AW (1..3)
//   IRQ_LEVEL : FIFO count at or above which o_irq asserts
//               (present only with LFSR_FIFO_IRQ_EN)
//
// Optional feature macro: LFSR_FIFO_IRQ_EN adds the registered level
// interrupt o_irq = (count >= IRQ_LEVEL) | overflow.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous, active-high reset
//   i_bit        serial random bit
//   i_bit_valid  i_bit is sampled this cycle when high
//   i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr[1:0], i_wb_data[7:0]
//                Wishbone slave request
//   o_wb_stall   always 0
//   o_wb_ack     registered acknowledge, one cycle after the strobe
//   o_wb_data    registered read data
//   o_irq        level interrupt (LFSR_FIFO_IRQ_EN only)
// -----------------------------------------------------------------------------
module lfsr_byte_fifo #(
    parameter int FIFO_AW = 3
`ifdef LFSR_FIFO_IRQ_EN
    ,
    parameter int IRQ_LEVEL = 4
`endif
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    input  logic       i_wb_cyc,
    input  logic       i_wb_stb,
    input  logic       i_wb_we,
    input  logic [1:0] i_wb_addr,
    input  logic [7:0] i_wb_data,
    output logic       o_wb_stall,
    output logic       o_wb_ack,
    output logic [7:0] o_wb_data
`ifdef LFSR_FIFO_IRQ_EN
    ,
    output logic       o_irq
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    // State registers and their next values
    logic [7:0]         shift,    shift_next;
    logic [2:0]         bit_cnt,  bit_cnt_next;
    logic [FIFO_AW-1:0] wr_ptr,   wr_ptr_next;
    logic [FIFO_AW-1:0] rd_ptr,   rd_ptr_next;
    logic [CW-1:0]      count,    count_next;
    logic               overflow, overflow_next;
    logic               enable,   enable_next;

    logic [7:0] mem [DEPTH];

    // Decoded events for this cycle
    logic       wb_req;
    logic       ctrl_wr;
    logic       clear;
    logic       capture;
    logic       push;
    logic       push_ok;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] push_byte;
    logic [7:0] status;
    logic [7:0] rd_mux;

    // Only bits [1:0] of a write carry meaning (CTRL).
    logic unused_wdata;
    assign unused_wdata = &{1'b0, i_wb_data[7:2]};

    assign o_wb_stall = 1'b0;

    assign wb_req  = i_wb_cyc & i_wb_stb;
    assign ctrl_wr = wb_req & i_wb_we & (i_wb_addr == ADDR_CTRL);
    assign clear   = ctrl_wr & i_wb_data[1];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Capture uses the enable register as it stands before any CTRL write
    // landing on this same edge.
    assign capture   = enable & i_bit_valid;
    assign push      = capture & (bit_cnt == 3'd7);
    assign push_byte = {shift[6:0], i_bit};
    assign pop       = wb_req & ~i_wb_we & (i_wb_addr == ADDR_DATA) & ~empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is
    // still accepted in that case.
    assign push_ok   = push & (~full | pop);

    assign status = {enable, overflow, full, empty, 4'(count)};

    always_comb begin
        rd_mux = 8'h00;
        case (i_wb_addr)
            ADDR_DATA:   rd_mux = empty ? 8'h00 : mem[rd_ptr];
            ADDR_STATUS: rd_mux = status;
            ADDR_CTRL:   rd_mux = {7'b0, enable};
            default:     rd_mux = 8'h00;
        endcase
    end

    // NOTE: every next-state variable takes its hold value first, so no path
    // through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        shift_next    = shift;
        bit_cnt_next  = bit_cnt;
        wr_ptr_next   = wr_ptr;
        rd_ptr_next   = rd_ptr;
        count_next    = count;
        overflow_next = overflow;
        enable_next   = enable;

        if (capture) begin
            shift_next   = push_byte;
            bit_cnt_next = bit_cnt + 3'd1;   // 7 wraps to 0 as the byte completes
        end

        if (pop) begin
            rd_ptr_next = rd_ptr + FIFO_AW'(1);
        end
        if (push_ok) begin
            wr_ptr_next = wr_ptr + FIFO_AW'(1);
        end

        if (push_ok && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push_ok) begin
            count_next = count - CW'(1);
        end

        if (push && !push_ok) begin
            overflow_next = 1'b1;
        end

        if (ctrl_wr) begin
            enable_next = i_wb_data[0];
        end

        // Clear overrides any push, pop or bit arriving on the same edge.
        if (clear) begin
            shift_next    = 8'h00;
            bit_cnt_next  = 3'd0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift     <= 8'h00;
            bit_cnt   <= 3'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            enable    <= 1'b0;
            o_wb_ack  <= 1'b0;
            o_wb_data <= 8'h00;
        end else begin
            shift    <= shift_next;
            bit_cnt  <= bit_cnt_next;
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            overflow <= overflow_next;
            enable   <= enable_next;
            o_wb_ack <= wb_req;
            if (wb_req) begin
                // Holds the pre-pop head for DATA reads; writes return 0x00.
                o_wb_data <= i_wb_we ? 8'h00 : rd_mux;
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge i_clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= push_byte;
        end
    end

`ifdef LFSR_FIFO_IRQ_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= (int'(count_next) >= IRQ_LEVEL) | overflow_next;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_byte_fifo.sv
// -----------------------------------------------------------------------------
// tb_lfsr_byte_fifo
//
// Self-checking bench for lfsr_byte_fifo (FIFO_AW = 3, depth 8). A queue-based
// reference model tracks the packed bits, the byte queue, enable and the
// sticky overflow flag; every bus transaction is compared against it, and the
// directed sequences also compare against fixed expected values.
// -----------------------------------------------------------------------------
module tb_lfsr_byte_fifo;

    localparam int DEPTH     = 8;
    localparam int IRQ_LEVEL = 4;

    typedef enum int { OP_NONE, OP_RD, OP_WR } op_e;
    typedef enum int { K_BIT, K_WR, K_RD } kind_e;

    typedef struct {
        kind_e       kind;
        logic [1:0]  addr;
        logic [7:0]  data;   // write data, or bit value in data[0]
        logic [7:0]  exp;    // expected read data (K_RD only)
        string       name;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_bit = 1'b0;
    logic       i_bit_valid = 1'b0;
    logic       i_wb_cyc = 1'b0;
    logic       i_wb_stb = 1'b0;
    logic       i_wb_we = 1'b0;
    logic [1:0] i_wb_addr = 2'd0;
    logic [7:0] i_wb_data = 8'h00;
    logic       o_wb_stall;
    logic       o_wb_ack;
    logic [7:0] o_wb_data;
`ifdef LFSR_FIFO_IRQ_EN
    logic       o_irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_en;
    logic       m_ovf;
    int         m_part;
    int         m_nb;

    lfsr_byte_fifo #(
        .FIFO_AW(3)
`ifdef LFSR_FIFO_IRQ_EN
        ,
        .IRQ_LEVEL(IRQ_LEVEL)
`endif
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_bit      (i_bit),
        .i_bit_valid(i_bit_valid),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_stall (o_wb_stall),
        .o_wb_ack   (o_wb_ack),
        .o_wb_data  (o_wb_data)
`ifdef LFSR_FIFO_IRQ_EN
        ,
        .o_irq      (o_irq)
`endif
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_q.delete();
        m_en   = 1'b0;
        m_ovf  = 1'b0;
        m_part = 0;
        m_nb   = 0;
    endfunction

    function automatic logic [7:0] model_status();
        int sz = m_q.size();
        return {m_en, m_ovf, sz == DEPTH, sz == 0, 4'(sz)};
    endfunction

    function automatic logic [7:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return (m_q.size() > 0) ? m_q[0] : 8'h00;
            2'd1:    return model_status();
            2'd2:    return {7'b0, m_en};
            default: return 8'h00;
        endcase
    endfunction

    // One clock edge worth of behaviour: pop, then the bit (with the enable
    // that held before the edge), then any CTRL write, whose clear wins.
    function automatic void model_apply(input logic bv, input logic b, input op_e op,
                                        input logic [1:0] a, input logic [7:0] wd);
        logic en_pre = m_en;
        if (op == OP_RD && a == 2'd0 && m_q.size() > 0) void'(m_q.pop_front());
        if (bv && en_pre) begin
            m_part = ((m_part * 2) + int'(b)) % 256;
            m_nb++;
            if (m_nb == 8) begin
                m_nb = 0;
                if (m_q.size() < DEPTH) m_q.push_back(8'(m_part));
                else m_ovf = 1'b1;
            end
        end
        if (op == OP_WR && a == 2'd2) begin
            m_en = wd[0];
            if (wd[1]) begin
                m_q.delete();
                m_nb   = 0;
                m_part = 0;
                m_ovf  = 1'b0;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic bv, input logic b, input op_e op,
                        input logic [1:0] a, input logic [7:0] wd, output logic [7:0] rd);
        logic [7:0] exp_rd;
        exp_rd      = model_read(a);
        i_bit_valid = bv;
        i_bit       = b;
        i_wb_cyc    = (op != OP_NONE);
        i_wb_stb    = (op != OP_NONE);
        i_wb_we     = (op == OP_WR);
        i_wb_addr   = a;
        i_wb_data   = wd;
        @(posedge i_clk);
        #1;
        i_bit_valid = 1'b0;
        i_wb_cyc    = 1'b0;
        i_wb_stb    = 1'b0;
        i_wb_we     = 1'b0;
        model_apply(bv, b, op, a, wd);
        check("ack", {7'b0, o_wb_ack}, {7'b0, op != OP_NONE});
        check("stall", {7'b0, o_wb_stall}, 8'h00);
        rd = o_wb_data;
        if (op == OP_RD) check("rdata_model", o_wb_data, exp_rd);
`ifdef LFSR_FIFO_IRQ_EN
        check("irq_model", {7'b0, o_irq},
              {7'b0, (m_q.size() >= IRQ_LEVEL) || m_ovf});
`endif
    endtask

    task automatic send_bit(input logic b);
        logic [7:0] rd;
        step(1'b1, b, OP_NONE, 2'd0, 8'h00, rd);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] rd;
        step(1'b0, 1'b0, OP_WR, a, d, rd);
    endtask

    task automatic wb_rd(input logic [1:0] a, input logic [7:0] exp, input string name);
        logic [7:0] rd;
        step(1'b0, 1'b0, OP_RD, a, 8'h00, rd);
        check(name, rd, exp);
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        model_reset();
    endtask

    vec_t tbl[$];

    initial begin
        logic [7:0] rd;
        logic [7:0] pat;

        model_reset();
        @(posedge i_clk);
        #1;
        check("reset_ack", {7'b0, o_wb_ack}, 8'h00);
        check("reset_data", o_wb_data, 8'h00);
`ifdef LFSR_FIFO_IRQ_EN
        check("reset_irq", {7'b0, o_irq}, 8'h00);
`endif
        i_reset = 1'b0;

        // ---------------- table-driven basic sequence ----------------
        tbl.push_back('{K_RD, 2'd1, 8'h00, 8'h10, "status_after_reset"});
        tbl.push_back('{K_WR, 2'd2, 8'h01, 8'h00, ""});
        tbl.push_back('{K_BIT, 2'd0, 8'h01, 8'h00, ""});
        tbl.push_back('{K_BIT, 2'd0, 8'h00, 8'h00, ""});
        tbl.push_back('{K_BIT, 2'd0, 8'h01, 8'h00, ""});
        tbl.push_back('{K_BIT, 2'd0, 8'h00, 8'h00, ""});
        tbl.push_back('{K_BIT, 2'd0, 8'h00, 8'h00, ""});
        tbl.push_back('{K_BIT, 2'd0, 8'h01, 8'h00, ""});
        tbl.push_back('{K_BIT, 2'd0, 8'h00, 8'h00, ""});
        tbl.push_back('{K_BIT, 2'd0, 8'h01, 8'h00, ""});
        tbl.push_back('{K_RD, 2'd1, 8'h00, 8'h81, "status_one_byte"});
        tbl.push_back('{K_RD, 2'd0, 8'h00, 8'hA5, "data_a5"});
        tbl.push_back('{K_RD, 2'd1, 8'h00, 8'h90, "status_empty_en"});
        tbl.push_back('{K_RD, 2'd0, 8'h00, 8'h00, "data_empty"});
        tbl.push_back('{K_RD, 2'd1, 8'h00, 8'h90, "status_after_empty_rd"});
        tbl.push_back('{K_RD, 2'd2, 8'h00, 8'h01, "ctrl_readback"});
        tbl.push_back('{K_RD, 2'd3, 8'h00, 8'h00, "addr3_read"});
        tbl.push_back('{K_WR, 2'd0, 8'h55, 8'h00, ""});
        tbl.push_back('{K_WR, 2'd1, 8'hFF, 8'h00, ""});
        tbl.push_back('{K_WR, 2'd3, 8'hFF, 8'h00, ""});
        tbl.push_back('{K_RD, 2'd1, 8'h00, 8'h90, "status_after_ign_wr"});
        tbl.push_back('{K_RD, 2'd3, 8'h00, 8'h00, "addr3_after_wr"});

        foreach (tbl[i]) begin
            case (tbl[i].kind)
                K_BIT: send_bit(tbl[i].data[0]);
                K_WR:  wb_wr(tbl[i].addr, tbl[i].data);
                default: wb_rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
            endcase
        end

        // ack must drop on the cycle after a lone strobe
        step(1'b0, 1'b0, OP_NONE, 2'd0, 8'h00, rd);

        // ---------------- overflow: 9 bytes of 0xFF ----------------
        for (int i = 0; i < 9; i++) send_bits(8'hFF, 8);
        wb_rd(2'd1, 8'hE8, "status_overflow_full");
        for (int i = 0; i < 8; i++) wb_rd(2'd0, 8'hFF, "data_ff");
        wb_rd(2'd1, 8'hD0, "status_drained_ovf");
        wb_wr(2'd2, 8'h03);
        wb_rd(2'd1, 8'h90, "status_after_clear");

        // ---------------- clear mid-byte ----------------
        send_bits(8'($urandom), 5);
        wb_wr(2'd2, 8'h03);
        send_bits(8'h3C, 8);
        wb_rd(2'd1, 8'h81, "status_after_3c");
        wb_rd(2'd0, 8'h3C, "data_3c_no_leftover");

        // ---------------- enable cleared on the completing bit ----------------
        send_bits(8'h5A, 7);
        step(1'b1, 1'b0, OP_WR, 2'd2, 8'h00, rd);
        wb_rd(2'd1, 8'h01, "status_en_off_byte_kept");
        wb_rd(2'd0, 8'h5A, "data_5a");
        send_bits(8'hFF, 8);
        wb_rd(2'd1, 8'h10, "status_bits_ignored");

        // ---------------- partial byte kept across enable toggle ----------------
        wb_wr(2'd2, 8'h01);
        send_bits(8'hC3, 4);
        wb_wr(2'd2, 8'h00);
        send_bits(8'h0F, 4);
        wb_wr(2'd2, 8'h01);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        wb_rd(2'd0, 8'hC3, "data_c3_partial_kept");

        // ---------------- push and pop on the same edge while full ----------------
        for (int i = 0; i < 8; i++) begin
            pat = 8'(i * 17 + 1);
            send_bits(pat, 8);
        end
        wb_rd(2'd1, 8'hA8, "status_full_no_ovf");
        send_bits(8'h99, 7);
        step(1'b1, 1'b1, OP_RD, 2'd0, 8'h00, rd);
        check("data_pop_push_full", rd, 8'h01);
        wb_rd(2'd1, 8'hA8, "status_still_full_no_ovf");

        // ---------------- clear on the same edge as a push ----------------
        send_bits(8'h77, 8);
        wb_rd(2'd1, 8'hE8, "status_ovf_before_clr");
        send_bits(8'h66, 7);
        step(1'b1, 1'b0, OP_WR, 2'd2, 8'h03, rd);
        wb_rd(2'd1, 8'h90, "status_clear_wins");

        // ---------------- asynchronous reset mid-byte ----------------
        for (int i = 0; i < 3; i++) send_bits(8'($urandom), 8);
        send_bits(8'hE0, 3);
        wb_rd(2'd1, 8'h83, "status_3_queued");
        #2;
        i_reset = 1'b1;
        #1;
        check("async_rst_ack", {7'b0, o_wb_ack}, 8'h00);
        check("async_rst_data", o_wb_data, 8'h00);
`ifdef LFSR_FIFO_IRQ_EN
        check("async_rst_irq", {7'b0, o_irq}, 8'h00);
`endif
        pulse_reset();
        wb_rd(2'd1, 8'h10, "status_after_reset_rel");
        wb_wr(2'd2, 8'h01);
        send_bits(8'h96, 8);
        wb_rd(2'd0, 8'h96, "data_clean_after_reset");

`ifdef LFSR_FIFO_IRQ_EN
        // ---------------- interrupt threshold ----------------
        for (int i = 0; i < 3; i++) send_bits(8'h11, 8);
        send_bits(8'h44, 7);
        check("irq_low_at_3", {7'b0, o_irq}, 8'h00);
        send_bit(1'b0);
        check("irq_rise_at_4", {7'b0, o_irq}, 8'h01);
        wb_rd(2'd0, 8'h11, "irq_pop_data");
        check("irq_fall_at_3", {7'b0, o_irq}, 8'h00);
        wb_wr(2'd2, 8'h03);
`endif

        // ---------------- randomized traffic vs reference model ----------------
        pulse_reset();
        wb_wr(2'd2, 8'h01);
        for (int blk = 0; blk < 6; blk++) begin
            int rd_pct = (blk % 2 == 1) ? 40 : 4;
            for (int n = 0; n < 500; n++) begin
                logic       bv = ($urandom_range(0, 99) < 70);
                logic       b  = 1'($urandom);
                int         r  = $urandom_range(0, 99);
                op_e        op = OP_NONE;
                logic [1:0] a  = 2'd0;
                logic [7:0] wd = 8'($urandom);
                if (r < rd_pct) begin
                    op = OP_RD;
                    a  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
                end else if (r < rd_pct + 4) begin
                    op = OP_WR;
                    a  = 2'd2;
                    wd[0] = ($urandom_range(0, 9) != 0);
                    wd[1] = ($urandom_range(0, 9) == 0);
                end else if (r < rd_pct + 6) begin
                    op = OP_WR;
                    a  = 2'($urandom_range(0, 3));
                    if (a == 2'd2) a = 2'd3;
                end
                step(bv, b, op, a, wd, rd);
            end
            wb_rd(2'd1, model_status(), "status_block_end");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
